// File: rtl/glitch_sweep_sched_pkg.sv
// glitch_sweep_sched_pkg: state encoding and default timing for the glitch sweep sequencer
package glitch_sweep_sched_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_POWER_OFF, S_BOOT, S_ARM, S_DELAY, S_GLITCH, S_OBSERVE
    } state_t;
    localparam int CLK_HZ          = 25000000;
    localparam int RESET_LEN_DEF   = 25000000;
    localparam int BOOT_LEN_DEF    = 25000000;
    localparam int OFFSET_MIN_DEF  = 0;
    localparam int OFFSET_MAX_DEF  = 255;
    localparam int OFFSET_STEP_DEF = 1;
    localparam int WIDTH_MIN_DEF   = 1;
    localparam int WIDTH_MAX_DEF   = 8;
    localparam int TRIES_DEF       = 16;
    localparam int ARM_TIMEOUT_DEF = 2500000;
    localparam int OBS_LEN_DEF     = 250000;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/glitch_sweep_sched_sync2.sv
// glitch_sweep_sched_sync2: 2-FF synchronizer with level and rising-edge outputs
module glitch_sweep_sched_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);
    logic [2:0] r_sh;
    always_ff @(posedge i_clk) r_sh <= i_rst ? 3'b000 : {r_sh[1:0], i_d};
    assign o_level = r_sh[1];
    assign o_rise  = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/glitch_sweep_sched.sv
// glitch_sweep_sched: offset x width power-glitch sweep sequencer driving the target power gate
module glitch_sweep_sched
    import glitch_sweep_sched_pkg::*;
#(
    parameter int RESET_LEN   = RESET_LEN_DEF,
    parameter int BOOT_LEN    = BOOT_LEN_DEF,
    parameter int OFFSET_MIN  = OFFSET_MIN_DEF,
    parameter int OFFSET_MAX  = OFFSET_MAX_DEF,
    parameter int OFFSET_STEP = OFFSET_STEP_DEF,
    parameter int WIDTH_MIN   = WIDTH_MIN_DEF,
    parameter int WIDTH_MAX   = WIDTH_MAX_DEF,
    parameter int TRIES       = TRIES_DEF,
    parameter int ARM_TIMEOUT = ARM_TIMEOUT_DEF,
    parameter int OBS_LEN     = OBS_LEN_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_trig,
    input  logic        i_fault,
    output logic        o_pwr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_hit,
    output logic [15:0] o_hit_offset,
    output logic [7:0]  o_hit_width,
    output logic        o_led1,
    output logic        o_led2,
    output logic        o_led3,
    output logic        o_led4
);
    // the shared counter also times DELAY and GLITCH, so it must hold offset and width too
    localparam int CNT_MAX = max2(max2(max2(RESET_LEN, BOOT_LEN), max2(ARM_TIMEOUT, OBS_LEN)),
                                  max2(OFFSET_MAX, WIDTH_MAX));
    localparam int CW = $clog2(CNT_MAX + 1);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_offset, r_try, r_hit_offset;
    logic [7:0]    r_width, r_hit_width;
    logic          r_pwr, r_busy, r_done, r_hit;
    logic          w_trig_rise, w_fault, w_unused_trig, w_unused_fault;
    logic          w_try_last, w_width_last, w_off_last, w_sweep_last;
    logic [16:0]   w_off_next;
    glitch_sweep_sched_sync2 u_sync_trig (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_trig), .o_level(w_unused_trig), .o_rise(w_trig_rise)
    );
    glitch_sweep_sched_sync2 u_sync_fault (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(i_fault), .o_level(w_fault), .o_rise(w_unused_fault)
    );
    assign w_try_last   = (32'(r_try) + 32'd1) >= 32'(TRIES);
    assign w_width_last = r_width >= 8'(WIDTH_MAX);
    assign w_off_next   = {1'b0, r_offset} + 17'(OFFSET_STEP);
    assign w_off_last   = w_off_next > 17'(OFFSET_MAX);
    assign w_sweep_last = w_try_last & w_width_last & w_off_last;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_offset     <= '0;
            r_width      <= '0;
            r_try        <= '0;
            r_pwr        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_offset <= '0;
            r_hit_width  <= '0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state  <= S_POWER_OFF;
                    r_cnt    <= CW'(RESET_LEN - 1);
                    r_offset <= 16'(OFFSET_MIN);
                    r_width  <= 8'(WIDTH_MIN);
                    r_try    <= '0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b1;
                end
                S_POWER_OFF: if (r_cnt == '0) begin
                    r_state <= S_BOOT;
                    r_cnt   <= CW'(BOOT_LEN - 1);
                    r_pwr   <= 1'b1;
                end else r_cnt <= r_cnt - 1'b1;
                S_BOOT: if (r_cnt == '0) begin
                    r_state <= S_ARM;
                    r_cnt   <= CW'(ARM_TIMEOUT - 1);
                end else r_cnt <= r_cnt - 1'b1;
                S_ARM: if (w_trig_rise) begin
                    r_state <= (r_offset == '0) ? S_GLITCH : S_DELAY;
                    r_cnt   <= (r_offset == '0) ? CW'(r_width - 8'd1) : CW'(r_offset - 16'd1);
                    r_pwr   <= r_offset != '0;
                end else if (r_cnt == '0) begin
                    r_state <= S_POWER_OFF;
                    r_cnt   <= CW'(RESET_LEN - 1);
                    r_pwr   <= 1'b0;
                end else r_cnt <= r_cnt - 1'b1;
                S_DELAY: if (r_cnt == '0) begin
                    r_state <= S_GLITCH;
                    r_cnt   <= CW'(r_width - 8'd1);
                    r_pwr   <= 1'b0;
                end else r_cnt <= r_cnt - 1'b1;
                S_GLITCH: if (r_cnt == '0) begin
                    r_state <= S_OBSERVE;
                    r_cnt   <= CW'(OBS_LEN - 1);
                    r_pwr   <= 1'b1;
                end else r_cnt <= r_cnt - 1'b1;
                S_OBSERVE: if (w_fault || r_cnt == '0) begin
                    r_hit <= w_fault;
                    if (w_fault) begin
                        r_hit_offset <= r_offset;
                        r_hit_width  <= r_width;
                    end
                    r_try    <= w_try_last ? '0 : r_try + 16'd1;
                    r_width  <= !w_try_last ? r_width : (w_width_last ? 8'(WIDTH_MIN) : r_width + 8'd1);
                    r_offset <= (w_try_last && w_width_last) ? w_off_next[15:0] : r_offset;
                    r_state  <= w_sweep_last ? S_IDLE : (w_fault ? S_POWER_OFF : S_ARM);
                    r_cnt    <= w_fault ? CW'(RESET_LEN - 1) : CW'(ARM_TIMEOUT - 1);
                    r_pwr    <= !w_sweep_last && !w_fault;
                    r_done   <= w_sweep_last;
                    r_busy   <= !w_sweep_last;
                end else r_cnt <= r_cnt - 1'b1;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_pwr        = r_pwr;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_hit        = r_hit;
    assign o_hit_offset = r_hit_offset;
    assign o_hit_width  = r_hit_width;
    assign o_led1       = r_state == S_POWER_OFF;
    assign o_led2       = r_state == S_BOOT;
    assign o_led3       = r_state == S_ARM;
    assign o_led4       = r_done;
endmodule

// File: tb/tb_glitch_sweep_sched.sv
// tb_glitch_sweep_sched: directed/random sweep bench with a spec-level timing model
module tb_glitch_sweep_sched;
    localparam int OBS = 8;
    logic clk = 0, rst = 1, start_a = 0, start_b = 0, trig = 0, fault = 0, sel = 0;
    logic a_pwr, a_busy, a_done, a_hit, a_l1, a_l2, a_l3, a_l4;
    logic b_pwr, b_busy, b_done, b_hit, b_l1, b_l2, b_l3, b_l4;
    logic [15:0] a_hoff, b_hoff;
    logic [7:0]  a_hw, b_hw;
    logic m_pwr, m_busy, m_done, m_hit, m_led1, m_led3;
    logic [3:0]  m_leds;
    logic [15:0] m_hoff;
    logic [7:0]  m_hw;
    int cyc = 0, hits = 0, total = 0, bad = 0, last_hi = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (m_hit === 1'b1) hits++;

    glitch_sweep_sched #(
        .RESET_LEN(10), .BOOT_LEN(10), .OFFSET_MIN(0), .OFFSET_MAX(2), .OFFSET_STEP(1),
        .WIDTH_MIN(1), .WIDTH_MAX(2), .TRIES(1), .ARM_TIMEOUT(20), .OBS_LEN(OBS)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_trig(trig), .i_fault(fault),
        .o_pwr(a_pwr), .o_busy(a_busy), .o_done(a_done), .o_hit(a_hit),
        .o_hit_offset(a_hoff), .o_hit_width(a_hw),
        .o_led1(a_l1), .o_led2(a_l2), .o_led3(a_l3), .o_led4(a_l4)
    );
    glitch_sweep_sched #(
        .RESET_LEN(4), .BOOT_LEN(4), .OFFSET_MIN(5), .OFFSET_MAX(5), .OFFSET_STEP(1),
        .WIDTH_MIN(3), .WIDTH_MAX(3), .TRIES(2), .ARM_TIMEOUT(20), .OBS_LEN(OBS)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_trig(trig), .i_fault(fault),
        .o_pwr(b_pwr), .o_busy(b_busy), .o_done(b_done), .o_hit(b_hit),
        .o_hit_offset(b_hoff), .o_hit_width(b_hw),
        .o_led1(b_l1), .o_led2(b_l2), .o_led3(b_l3), .o_led4(b_l4)
    );

    assign m_pwr  = sel ? b_pwr  : a_pwr;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;
    assign m_hit  = sel ? b_hit  : a_hit;
    assign m_hoff = sel ? b_hoff : a_hoff;
    assign m_hw   = sel ? b_hw   : a_hw;
    assign m_leds = sel ? {b_l1, b_l2, b_l3, b_l4} : {a_l1, a_l2, a_l3, a_l4};
    assign m_led1 = m_leds[3];
    assign m_led3 = m_leds[1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_arm(input string tag);
        int n = 0;
        while (m_led3 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk(tag, 32'(m_led3), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (m_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_time"}, cyc - last_hi, OBS);
        chk({tag, "_done"}, 32'(m_done), 1);
        chk({tag, "_busy"}, 32'(m_busy), 0);
    endtask

    // one attempt: trigger from the target, expect PWR low at trig+offset+3 for width cycles
    task automatic attempt(input bit do_fault, input int off, input int w);
        int k, n;
        wait_arm("arm_wait");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        trig = 1; k = cyc; n = 0;
        do begin @(negedge clk); n++; end while (m_pwr !== 1'b0 && n < 40);
        chk("glitch_start", cyc - k, off + 3);
        n = 0;
        while (m_pwr === 1'b0 && n < 40) begin @(negedge clk); n++; end
        chk("glitch_width", n, w);
        last_hi = cyc; trig = 0;
        if (do_fault) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            fault = 1; k = cyc; n = 0;
            do begin @(negedge clk); n++; end while (m_hit !== 1'b1 && n < 20);
            fault = 0;
            chk("hit_latency", cyc - k, 3);
            chk("hit_offset", 32'(m_hoff), off);
            chk("hit_width", 32'(m_hw), w);
            chk("hit_to_poweroff", 32'(m_led1), 1);
            @(negedge clk);
            chk("hit_one_cycle", 32'(m_hit), 0);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_pwr", 32'(m_pwr), 0);
        chk("rst_busy", 32'(m_busy), 0);
        chk("rst_done", 32'(m_done), 0);
        chk("rst_hit", 32'(m_hit), 0);
        chk("rst_hoff", 32'(m_hoff), 0);
        chk("rst_hw", 32'(m_hw), 0);
        chk("rst_leds", 32'(m_leds), 0);
        rst = 0;
        start_a = 1; @(negedge clk); start_a = 0;
        chk("busy_rise", 32'(m_busy), 1);
        chk("start_poweroff", 32'(m_led1), 1);
        chk("start_pwr", 32'(m_pwr), 0);
        trig = 1; repeat (2) @(negedge clk); trig = 0;
        wait_arm("arm_first");
        n = 0;
        while (m_led3 === 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("arm_timeout_len", n, 20);
        chk("timeout_poweroff", 32'(m_led1), 1);
        for (int off = 0; off <= 2; off++)
            for (int w = 1; w <= 2; w++) begin
                attempt(off == 1 && w == 2, off, w);
                if (off == 0 && w == 2) begin
                    start_a = 1; @(negedge clk); start_a = 0;
                    chk("busy_hold", 32'(m_busy), 1);
                end
            end
        wait_done("sweep_a");
        chk("led4_done", 32'(m_leds[0]), 1);
        chk("hit_count", hits, 1);
        start_a = 1; @(negedge clk); start_a = 0;
        chk("restart_done_clr", 32'(m_done), 0);
        wait_arm("arm_rst");
        trig = 1; n = 0;
        while (m_pwr !== 1'b0 && n < 40) begin @(negedge clk); n++; end
        rst = 1; start_a = 1;
        @(negedge clk);
        rst = 0; start_a = 0; trig = 0;
        chk("rst_glitch_pwr", 32'(m_pwr), 0);
        chk("rst_glitch_busy", 32'(m_busy), 0);
        chk("rst_glitch_leds", 32'(m_leds), 0);
        @(negedge clk);
        chk("rst_start_ignored", 32'(m_busy), 0);
        sel = 1;
        repeat (3) @(negedge clk);
        start_b = 1; @(negedge clk); start_b = 0;
        chk("b_busy_rise", 32'(m_busy), 1);
        attempt(0, 5, 3);
        attempt(0, 5, 3);
        wait_done("sweep_b");
        chk("b_no_hit", hits, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
